// File: rtl/iic_pkg.sv
// Shared definitions for the IIC controller phase blocks.
//   - 4-bit phase codes carried on the shared state bus
//   - FSM state encoding of the read-byte/ACK phase block
//   - SCL divider strobe bundle and its priority resolution
//     (scl_hc > scl_ls > scl_lc when a divider fault makes them coincide)
package iic_pkg;

    localparam logic [3:0] PH_IDLE   = 4'd0;
    localparam logic [3:0] PH_START  = 4'd1;
    localparam logic [3:0] PH_ADDR   = 4'd2;
    localparam logic [3:0] PH_WRACK  = 4'd3;
    localparam logic [3:0] PH_WRBYTE = 4'd4;
    localparam logic [3:0] PH_RDBYTE = 4'd6;
    localparam logic [3:0] PH_RDACK  = 4'd7;
    localparam logic [3:0] PH_STOP   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ACK   = 2'd2,
        ST_DONE  = 2'd3
    } rdack_state_e;

    // Strobes in the SCL period order: low start, low centre, high centre.
    typedef struct packed {
        logic hc;   // SCL high centre: sample point
        logic ls;   // SCL low start: SCL just fell
        logic lc;   // SCL low centre: SDA change point
    } scl_strb_t;

    // At most one strobe survives; the higher-priority one wins.
    function automatic scl_strb_t strb_resolve(input logic hc, input logic ls, input logic lc);
        scl_strb_t s;
        s.hc = hc;
        s.ls = ls & ~hc;
        s.lc = lc & ~hc & ~ls;
        return s;
    endfunction

endpackage

// File: rtl/iic_rd_byte_ack_if.sv
// Bus bundle of the read-byte/ACK phase block.
//   master : the phase block itself (consumes strobes/bus, drives SDA enable,
//            phase request and received data)
//   slave  : the controller side feeding strobes and the state bus
interface iic_rd_byte_ack_if;
    logic       scl_hc;
    logic       scl_ls;
    logic       scl_lc;
    logic [3:0] state;
    logic       nack_req;
    logic       sda_i;
    logic       sda_oe;
    logic [3:0] state_nxt;
    logic       state_we;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       ack_err;

    modport master (
        input  scl_hc, scl_ls, scl_lc, state, nack_req, sda_i,
        output sda_oe, state_nxt, state_we, rd_data, rd_valid, ack_err
    );

    modport slave (
        output scl_hc, scl_ls, scl_lc, state, nack_req, sda_i,
        input  sda_oe, state_nxt, state_we, rd_data, rd_valid, ack_err
    );
endinterface

// File: rtl/iic_rx_shreg.sv
// Receive shift register with bit counter.
//   clk, srst : clock, synchronous active-high reset
//   clr       : clear data and counter (phase entry)
//   smp       : shift in sda as new LSB (MSB first on the wire); ignored when full
//   sda       : sampled SDA level
//   data      : shifted byte
//   bcnt      : number of bits captured (0..8)
//   full      : bcnt == 8
module iic_rx_shreg (
    input  logic       clk,
    input  logic       srst,
    input  logic       clr,
    input  logic       smp,
    input  logic       sda,
    output logic [7:0] data,
    output logic [3:0] bcnt,
    output logic       full
);
    logic [7:0] shreg_reg;
    logic [3:0] bcnt_reg;
    logic       shift_en;

    assign full     = (bcnt_reg == 4'd8);
    assign shift_en = smp & ~full;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            shreg_reg[0] <= 1'b0;
            bcnt_reg     <= 4'd0;
        end else if (shift_en) begin
            shreg_reg[0] <= sda;
            bcnt_reg     <= bcnt_reg + 4'd1;
        end
    end

    // Upper bits each take their lower neighbour on a sample.
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (srst || clr) begin
                    shreg_reg[gi] <= 1'b0;
                end else if (shift_en) begin
                    shreg_reg[gi] <= shreg_reg[gi-1];
                end
            end
        end
    endgenerate

    assign data = shreg_reg;
    assign bcnt = bcnt_reg;
endmodule

// File: rtl/iic_rd_byte_ack.sv
// IIC master read-byte phase: while the shared state bus carries STATE_CODE,
// shift in one byte MSB first, drive ACK (SDA low) or NACK (released) in the
// 9th SCL period and request the next phase code.
// Optional feature macro: IIC_RDACK_CHECK_EN -- self-check that the driven ACK
// is seen on the bus at the 9th sample point; on failure pulse ack_err and
// hand over to STOP_CODE. Undefined: ack_err stays 0.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   en   : synchronous soft clear, same effect as rst
//   bus  : iic_rd_byte_ack_if.master (strobes, state bus, SDA, results)
module iic_rd_byte_ack
    import iic_pkg::*;
#(
    parameter logic [3:0] STATE_CODE = PH_RDBYTE,
    parameter logic [3:0] NEXT_CODE  = PH_RDACK,
    parameter logic [3:0] STOP_CODE  = PH_STOP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    iic_rd_byte_ack_if.master     bus
);
    rdack_state_e fsm_reg, fsm_next;
    logic         sda_oe_reg, sda_oe_next;
    logic [3:0]   state_nxt_reg, state_nxt_next;
    logic         state_we_reg, state_we_next;
    logic [7:0]   rd_data_reg, rd_data_next;
    logic         rd_valid_reg, rd_valid_next;
    logic         ack_err_reg, ack_err_next;
    logic         nack_l_reg, nack_l_next;
    logic         hc9_reg, hc9_next;
    logic         err_l_reg, err_l_next;
    logic         done_cnt_reg, done_cnt_next;

    logic         srst;
    logic         active;
    scl_strb_t    strb;
    logic         sh_clr, sh_smp, sh_full;
    logic [7:0]   sh_data;
    logic [3:0]   sh_bcnt;

    assign srst   = rst | en;
    assign active = (bus.state == STATE_CODE);
    assign strb   = strb_resolve(bus.scl_hc, bus.scl_ls, bus.scl_lc);

    iic_rx_shreg u_shreg (
        .clk  (clk),
        .srst (srst),
        .clr  (sh_clr),
        .smp  (sh_smp),
        .sda  (bus.sda_i),
        .data (sh_data),
        .bcnt (sh_bcnt),
        .full (sh_full)
    );

    always_comb begin
        fsm_next       = fsm_reg;
        sda_oe_next    = sda_oe_reg;
        state_nxt_next = state_nxt_reg;
        state_we_next  = 1'b0;
        rd_data_next   = rd_data_reg;
        rd_valid_next  = 1'b0;
        ack_err_next   = 1'b0;
        nack_l_next    = nack_l_reg;
        hc9_next       = hc9_reg;
        err_l_next     = err_l_reg;
        done_cnt_next  = done_cnt_reg;
        sh_clr         = 1'b0;
        sh_smp         = 1'b0;

        case (fsm_reg)
            ST_IDLE: begin
                if (active) begin
                    sh_clr     = 1'b1;
                    hc9_next   = 1'b0;
                    err_l_next = 1'b0;
                    fsm_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!active) begin
                    sda_oe_next = 1'b0;
                    fsm_next    = ST_IDLE;
                end else if (!sh_full) begin
                    sh_smp = strb.hc;
                end else if (strb.lc) begin
                    // The scl_ls after bit 0 falls through here unused; the
                    // ACK level goes out at the low centre like any data bit.
                    sda_oe_next = ~bus.nack_req;
                    nack_l_next = bus.nack_req;
                    fsm_next    = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!active) begin
                    sda_oe_next = 1'b0;
                    fsm_next    = ST_IDLE;
                end else if (strb.hc) begin
                    hc9_next = 1'b1;
`ifdef IIC_RDACK_CHECK_EN
                    // Our own pull-down should hold the line low; a high level
                    // means the bus is stuck or another driver interferes.
                    if (sda_oe_reg && bus.sda_i) begin
                        ack_err_next = 1'b1;
                        err_l_next   = 1'b1;
                    end
`endif
                end else if (strb.ls && hc9_reg) begin
                    sda_oe_next    = 1'b0;
                    rd_data_next   = sh_data;
                    rd_valid_next  = 1'b1;
                    state_we_next  = 1'b1;
                    state_nxt_next = (nack_l_reg || err_l_reg) ? STOP_CODE : NEXT_CODE;
                    done_cnt_next  = 1'b0;
                    fsm_next       = ST_DONE;
                end
            end
            ST_DONE: begin
                // Give the controller two clocks to move the bus; if the code
                // stays ours, re-arm so a fed-back STATE_CODE reads again.
                if (!active || done_cnt_reg) begin
                    fsm_next = ST_IDLE;
                end else begin
                    done_cnt_next = 1'b1;
                end
            end
            default: begin
                sda_oe_next = 1'b0;
                fsm_next    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            fsm_reg       <= ST_IDLE;
            sda_oe_reg    <= 1'b0;
            state_nxt_reg <= STATE_CODE;
            state_we_reg  <= 1'b0;
            rd_data_reg   <= 8'h00;
            rd_valid_reg  <= 1'b0;
            ack_err_reg   <= 1'b0;
            nack_l_reg    <= 1'b0;
            hc9_reg       <= 1'b0;
            err_l_reg     <= 1'b0;
            done_cnt_reg  <= 1'b0;
        end else begin
            fsm_reg       <= fsm_next;
            sda_oe_reg    <= sda_oe_next;
            state_nxt_reg <= state_nxt_next;
            state_we_reg  <= state_we_next;
            rd_data_reg   <= rd_data_next;
            rd_valid_reg  <= rd_valid_next;
            ack_err_reg   <= ack_err_next;
            nack_l_reg    <= nack_l_next;
            hc9_reg       <= hc9_next;
            err_l_reg     <= err_l_next;
            done_cnt_reg  <= done_cnt_next;
        end
    end

    assign bus.sda_oe    = sda_oe_reg;
    assign bus.state_nxt = state_nxt_reg;
    assign bus.state_we  = state_we_reg;
    assign bus.rd_data   = rd_data_reg;
    assign bus.rd_valid  = rd_valid_reg;
    assign bus.ack_err   = ack_err_reg;

    // Bit count is observed through sh_full; the raw count is for debug.
    logic unused_bcnt;
    assign unused_bcnt = ^sh_bcnt;
endmodule

// File: tb/tb_iic_rd_byte_ack.sv
// Directed bench for iic_rd_byte_ack: drives SCL divider strobes and SDA per
// bit, models the open-drain line in the ACK slot and checks results against
// hand-computed expectations. Honours IIC_RDACK_CHECK_EN for ack_err/next code.
module tb_iic_rd_byte_ack;
    import iic_pkg::*;

    localparam logic [3:0] CODE_ME   = 4'd6;
    localparam logic [3:0] CODE_NEXT = 4'd7;
    localparam logic [3:0] CODE_STOP = 4'd9;

    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    iic_rd_byte_ack_if bus ();

    iic_rd_byte_ack #(
        .STATE_CODE (CODE_ME),
        .NEXT_CODE  (CODE_NEXT),
        .STOP_CODE  (CODE_STOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_we     = 0;

    always @(posedge clk) begin
        if (bus.rd_valid) n_valid <= n_valid + 1;
        if (bus.state_we) n_we    <= n_we + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ls();
        bus.scl_ls = 1'b1; tick(); bus.scl_ls = 1'b0;
    endtask

    task automatic pulse_lc();
        bus.scl_lc = 1'b1; tick(); bus.scl_lc = 1'b0;
    endtask

    task automatic pulse_hc();
        bus.scl_hc = 1'b1; tick(); bus.scl_hc = 1'b0;
    endtask

    task automatic enter();
        bus.state = CODE_ME;
        tick();
        tick();
    endtask

    // Send the n most significant bits of b, one SCL period each.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            pulse_ls(); tick();
            bus.sda_i = b[i];
            pulse_lc(); tick();
            pulse_hc(); tick();
        end
    endtask

    // 9th SCL period plus the falling edge that ends it.
    task automatic finish_byte(input logic [7:0] b, input logic nack, input logic force_hi,
                               input string name);
        logic       exp_err;
        logic [3:0] exp_code;
`ifdef IIC_RDACK_CHECK_EN
        exp_err = !nack && force_hi;
`else
        exp_err = 1'b0;
`endif
        exp_code = (nack || exp_err) ? CODE_STOP : CODE_NEXT;
        bus.nack_req = nack;
        pulse_ls(); tick();
        check($sformatf("%s.oe_before_lc", name), bus.sda_oe, 1'b0);
        pulse_lc();
        check($sformatf("%s.oe_at_lc", name), bus.sda_oe, !nack);
        tick();
        // Open-drain line: low while we pull, unless forced high.
        bus.sda_i = force_hi | nack;
        pulse_hc();
        check($sformatf("%s.ack_err", name), bus.ack_err, exp_err);
        check($sformatf("%s.oe_hc9", name), bus.sda_oe, !nack);
        tick();
        check($sformatf("%s.ack_err_end", name), bus.ack_err, 1'b0);
        check($sformatf("%s.valid_early", name), bus.rd_valid, 1'b0);
        pulse_ls();
        check($sformatf("%s.rd_valid", name), bus.rd_valid, 1'b1);
        check($sformatf("%s.state_we", name), bus.state_we, 1'b1);
        check($sformatf("%s.rd_data", name), bus.rd_data, b);
        check($sformatf("%s.state_nxt", name), bus.state_nxt, exp_code);
        check($sformatf("%s.oe_rel", name), bus.sda_oe, 1'b0);
        tick();
        check($sformatf("%s.valid_pulse", name), bus.rd_valid, 1'b0);
        check($sformatf("%s.we_pulse", name), bus.state_we, 1'b0);
        $display("byte %s: data=%02h nack=%0b force_hi=%0b -> rd_data=%02h state_nxt=%0d ack_err_exp=%0b",
                 name, b, nack, force_hi, bus.rd_data, bus.state_nxt, exp_err);
    endtask

    initial begin
        int v0, w0;
        rst = 1'b1; en = 1'b0;
        bus.scl_hc = 1'b0; bus.scl_ls = 1'b0; bus.scl_lc = 1'b0;
        bus.state = 4'd0; bus.nack_req = 1'b0; bus.sda_i = 1'b1;
        tick(); tick();

        check("rst.sda_oe",    bus.sda_oe, 1'b0);
        check("rst.state_we",  bus.state_we, 1'b0);
        check("rst.rd_valid",  bus.rd_valid, 1'b0);
        check("rst.ack_err",   bus.ack_err, 1'b0);
        check("rst.rd_data",   bus.rd_data, 8'h00);
        check("rst.state_nxt", bus.state_nxt, CODE_ME);
        check("rst.fsm",       dut.fsm_reg, ST_IDLE);
        check("rst.bcnt",      dut.u_shreg.bcnt_reg, 4'd0);
        rst = 1'b0;

        // Inactive strobes do nothing.
        pulse_hc(); pulse_lc(); pulse_ls(); tick();
        check("idle.fsm", dut.fsm_reg, ST_IDLE);

        // ACKed byte.
        enter();
        send_bits(8'hA5, 8);
        finish_byte(8'hA5, 1'b0, 1'b0, "A5_ack");
        bus.state = 4'd0; tick(); tick();

        // Soft clear via en.
        en = 1'b1; tick(); en = 1'b0;
        check("en.rd_data", bus.rd_data, 8'h00);
        check("en.state_nxt", bus.state_nxt, CODE_ME);

        // NACKed byte.
        enter();
        send_bits(8'h3C, 8);
        finish_byte(8'h3C, 1'b1, 1'b0, "3C_nack");
        bus.state = 4'd0; tick(); tick();

        // Abort after 4 bits.
        v0 = n_valid; w0 = n_we;
        enter();
        send_bits(8'hC3, 4);
        bus.state = 4'd0; tick();
        check("abort.fsm", dut.fsm_reg, ST_IDLE);
        check("abort.oe", bus.sda_oe, 1'b0);
        for (int k = 0; k < 6; k++) tick();
        check("abort.no_valid", n_valid, v0);
        check("abort.no_we", n_we, w0);
        $display("abort after 4 bits: rd_valid pulses=%0d state_we pulses=%0d", n_valid - v0, n_we - w0);
        enter();
        check("reentry.bcnt", dut.u_shreg.bcnt_reg, 4'd0);
        send_bits(8'hFF, 8);
        finish_byte(8'hFF, 1'b0, 1'b0, "FF_reentry");
        bus.state = 4'd0; tick(); tick();

        // Reset while driving ACK.
        enter();
        send_bits(8'h5A, 8);
        bus.nack_req = 1'b0;
        pulse_ls(); tick();
        pulse_lc();
        check("rstack.oe_set", bus.sda_oe, 1'b1);
        tick();
        rst = 1'b1; tick();
        check("rstack.oe", bus.sda_oe, 1'b0);
        check("rstack.rd_data", bus.rd_data, 8'h00);
        check("rstack.fsm", dut.fsm_reg, ST_IDLE);
        rst = 1'b0; bus.state = 4'd0; tick(); tick();
        $display("reset during ACK: sda_oe=%0b rd_data=%02h", bus.sda_oe, bus.rd_data);

        // ACK intended but line stuck high at the 9th sample.
        enter();
        send_bits(8'h96, 8);
        finish_byte(8'h96, 1'b0, 1'b1, "96_stuck");
        bus.state = 4'd0; tick(); tick();

        // Back-to-back with the code held.
        enter();
        send_bits(8'h00, 8);
        finish_byte(8'h00, 1'b0, 1'b0, "00_b2b");
        tick(); tick();
        check("b2b.fsm", dut.fsm_reg, ST_SHIFT);
        check("b2b.bcnt", dut.u_shreg.bcnt_reg, 4'd0);
        send_bits(8'hFF, 8);
        finish_byte(8'hFF, 1'b0, 1'b0, "FF_b2b");
        bus.state = 4'd0; tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
